// File: rtl/mem_seg_pkg.sv
// Shared CPU definitions for the memory pipeline segment: opcode constants,
// memory-access FSM state encoding, the pipeline bubble value and opcode helpers.
package mem_seg_pkg;

    localparam logic [5:0]  OP_LW   = 6'b100011;
    localparam logic [5:0]  OP_SW   = 6'b101011;
    localparam logic [5:0]  OP_BEQZ = 6'b000100;

    localparam logic [31:0] BUBBLE  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    // True for opcodes that need a data-memory transaction
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Memory access sequencer for the MEM segment. Owns the IDLE/ACCESS state,
// the memory request/write-enable strobes and the upstream stall. State
// advances on the falling clock edge; rst is asynchronous active-low so the
// strobes drop immediately when reset is asserted mid-access.
module mem_access_fsm
    import mem_seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       start_we,
    input  logic       mem_ack,
    output mem_state_t state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       stall
);

    // Sequencer: launch an access on start, wait in ACCESS until ack
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            stall   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // mem_ack is deliberately not looked at here
                    if (start) begin
                        state   <= ST_ACCESS;
                        mem_req <= 1'b1;
                        mem_we  <= start_we;
                        stall   <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        stall   <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // No timeout: hold the request until memory answers
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        stall   <= 1'b0;
                    end else begin
                        state   <= ST_ACCESS;
                        mem_req <= mem_req;
                        mem_we  <= mem_we;
                        stall   <= stall;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_seg.sv
// MEM pipeline segment: latches the EX results on the falling clock edge,
// performs LW/SW through a request/ack memory port and resolves BEQZ.
// While an access is outstanding the segment stalls upstream and emits a
// bubble to WB so every instruction is committed exactly once.
// Optional build macro MEM_ALIGN_CHECK_EN adds a misalign output and
// suppresses accesses to non-word-aligned addresses.
module mem_seg
    import mem_seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IRi,
    input  logic [31:0] ALUi,
    input  logic [31:0] Bi,
    input  logic        condi,
    output logic [31:0] IRo,
    output logic [31:0] ALUo,
    output logic [31:0] LMDo,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    logic [31:0] ir_r;
    logic [31:0] alu_r;
    logic [31:0] b_r;
    logic        cond_r;
    logic [31:0] lmd_r;

    logic        capture_s;
    logic        start_s;
    logic        start_we_s;
    logic        in_access_s;
    logic        load_done_s;
    logic [5:0]  opc_in_s;
    mem_state_t  state_s;

`ifdef MEM_ALIGN_CHECK_EN
    logic        mis_in_s;
    logic        misalign_r;
`endif

    // New instructions enter only while no access is outstanding; this also
    // blocks capture on the ack edge because stall is still high then.
    assign capture_s   = ~stall;
    assign opc_in_s    = IRi[31:26];
    assign in_access_s = (state_s == ST_ACCESS);
    assign load_done_s = in_access_s && mem_ack && (ir_r[31:26] == OP_LW);

    // Decide whether the instruction being captured launches a memory access
    always_comb begin
        start_we_s = (opc_in_s == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
        mis_in_s   = is_mem_op(opc_in_s) && (ALUi[1:0] != 2'b00);
        start_s    = capture_s && is_mem_op(opc_in_s) && !mis_in_s;
`else
        start_s    = capture_s && is_mem_op(opc_in_s);
`endif
    end

    mem_access_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .start_we (start_we_s),
        .mem_ack  (mem_ack),
        .state    (state_s),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .stall    (stall)
    );

    // Pipeline latch for EX results and the load-data register
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ir_r   <= 32'h0000_0000;
            alu_r  <= 32'h0000_0000;
            b_r    <= 32'h0000_0000;
            cond_r <= 1'b0;
            lmd_r  <= 32'h0000_0000;
        end else begin
            if (capture_s) begin
                ir_r   <= IRi;
                alu_r  <= ALUi;
                b_r    <= Bi;
                cond_r <= condi;
            end
            if (load_done_s) begin
                lmd_r <= mem_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misalign flag tracks the most recently captured instruction
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else if (capture_s) begin
            misalign_r <= mis_in_s;
        end
    end

    assign misalign = misalign_r;
`endif

    // Instruction handed to WB: bubble while the access is outstanding
    always_comb begin
        if (in_access_s) begin
            IRo = BUBBLE;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (misalign_r) begin
            IRo = BUBBLE;
        end
`endif
        else begin
            IRo = ir_r;
        end
    end

    // Branch resolution from latched state, suppressed during an access
    always_comb begin
        branch_taken  = (!in_access_s) && (ir_r[31:26] == OP_BEQZ) && cond_r;
        branch_target = alu_r;
    end

    assign ALUo      = alu_r;
    assign LMDo      = lmd_r;
    assign mem_addr  = alu_r;
    assign mem_wdata = b_r;

endmodule

// File: tb/tb_mem_seg.sv
// Directed, table-driven bench for mem_seg. State changes on the falling
// edge; stimulus is applied and outputs are sampled 1 time unit after it.
module tb_mem_seg;

    localparam logic [31:0] W_LW   = 32'h8C22_0004;
    localparam logic [31:0] W_SW   = 32'hAC43_0008;
    localparam logic [31:0] W_BEQZ = 32'h1020_0010;
    localparam logic [31:0] W_ADD  = 32'h0022_1820;

    logic        clk;
    logic        rst;
    logic [31:0] IRi, ALUi, Bi;
    logic        condi;
    logic [31:0] IRo, ALUo, LMDo;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    mem_seg dut (
        .clk           (clk),
        .rst           (rst),
        .IRi           (IRi),
        .ALUi          (ALUi),
        .Bi            (Bi),
        .condi         (condi),
        .IRo           (IRo),
        .ALUo          (ALUo),
        .LMDo          (LMDo),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] b;
        logic        cond;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_iro;
        logic [31:0] e_aluo;
        logic [31:0] e_lmdo;
        logic        e_bt;
        logic [31:0] e_btg;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                         input logic cond, input logic ack, input logic [31:0] rdata);
        IRi       = ir;
        ALUi      = alu;
        Bi        = b;
        condi     = cond;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    initial begin
        // ir, alu, b, cond, ack, rdata | iro, aluo, lmdo, bt, btg, stall, req, we, addr, wdata
        vecs[0] = '{W_BEQZ, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0,
                    W_BEQZ, 32'h40, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0};
        vecs[1] = '{W_BEQZ, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0,
                    W_BEQZ, 32'h44, 32'h0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0};
        vecs[2] = '{W_SW, 32'h20, 32'h1234, 1'b0, 1'b0, 32'h0,
                    32'h0, 32'h20, 32'h0, 1'b0, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20, 32'h1234};
        vecs[3] = '{W_ADD, 32'h999, 32'h5, 1'b0, 1'b0, 32'h0,
                    32'h0, 32'h20, 32'h0, 1'b0, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20, 32'h1234};
        vecs[4] = '{W_ADD, 32'h999, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFF,
                    W_SW, 32'h20, 32'h0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h20, 32'h1234};
        vecs[5] = '{W_ADD, 32'h999, 32'h5, 1'b0, 1'b0, 32'h0,
                    W_ADD, 32'h999, 32'h0, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0, 32'h999, 32'h5};
        vecs[6] = '{W_LW, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1111_1111,
                    32'h0, 32'h100, 32'h0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0};
        vecs[7] = '{W_ADD, 32'h8, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D,
                    W_LW, 32'h100, 32'hCAFE_F00D, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0};
        vecs[8] = '{W_ADD, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0,
                    W_ADD, 32'h8, 32'hCAFE_F00D, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0};

        // Reset state
        rst = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #13;
        check("rst_iro",   IRo, 32'h0);
        check("rst_aluo",  ALUo, 32'h0);
        check("rst_lmdo",  LMDo, 32'h0);
        check("rst_bt",    {31'h0, branch_taken}, 32'h0);
        check("rst_btg",   branch_target, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req",   {31'h0, mem_req}, 32'h0);
        check("rst_addr",  mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        #3 rst = 1'b1;

        // Table: branch, store with held inputs, LW/ADD back-to-back with ack on first edge
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ir, vecs[i].alu, vecs[i].b, vecs[i].cond, vecs[i].ack, vecs[i].rdata);
            tick();
            check($sformatf("v%0d_iro", i),   IRo, vecs[i].e_iro);
            check($sformatf("v%0d_aluo", i),  ALUo, vecs[i].e_aluo);
            check($sformatf("v%0d_lmdo", i),  LMDo, vecs[i].e_lmdo);
            check($sformatf("v%0d_bt", i),    {31'h0, branch_taken}, {31'h0, vecs[i].e_bt});
            check($sformatf("v%0d_btg", i),   branch_target, vecs[i].e_btg);
            check($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            check($sformatf("v%0d_req", i),   {31'h0, mem_req}, {31'h0, vecs[i].e_req});
            check($sformatf("v%0d_we", i),    {31'h0, mem_we}, {31'h0, vecs[i].e_we});
            check($sformatf("v%0d_addr", i),  mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
        end

        // LW with the ack arriving after three stalled cycles
        drive(W_LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("lw3_stall%0d", c), {31'h0, stall}, 32'h1);
            check($sformatf("lw3_iro%0d", c),   IRo, 32'h0);
            check($sformatf("lw3_req%0d", c),   {31'h0, mem_req}, 32'h1);
            check($sformatf("lw3_lmd%0d", c),   LMDo, 32'hCAFE_F00D);
            drive(W_ADD, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        drive(W_ADD, 32'h4, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("lw3_lmd_done",   LMDo, 32'hDEAD_BEEF);
        check("lw3_iro_done",   IRo, W_LW);
        check("lw3_stall_done", {31'h0, stall}, 32'h0);
        check("lw3_aluo_done",  ALUo, 32'h100);

        // Reset asserted in the middle of an access
        drive(W_SW, 32'h60, 32'h77, 1'b0, 1'b0, 32'h0);
        tick();
        check("mid_req_before", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_req",   {31'h0, mem_req}, 32'h0);
        check("mid_we",    {31'h0, mem_we}, 32'h0);
        check("mid_stall", {31'h0, stall}, 32'h0);
        check("mid_iro",   IRo, 32'h0);
        check("mid_aluo",  ALUo, 32'h0);
        check("mid_lmdo",  LMDo, 32'h0);
        #2 rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
        tick();
        check("late_ack_lmd",   LMDo, 32'h0);
        check("late_ack_req",   {31'h0, mem_req}, 32'h0);
        check("late_ack_stall", {31'h0, stall}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load issues no access
        drive(W_LW, 32'h102, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("mis_flag",  {31'h0, misalign}, 32'h1);
        check("mis_req",   {31'h0, mem_req}, 32'h0);
        check("mis_stall", {31'h0, stall}, 32'h0);
        check("mis_iro",   IRo, 32'h0);
        drive(W_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("mis_clear", {31'h0, misalign}, 32'h0);
        check("mis_next",  IRo, W_ADD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_seg.md
MEM_SEG -- requirements
Module: mem_seg

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-low, port name rst.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 async active-low reset.
REQ-003 SHALL have inputs IRi 32 (instruction from EX), ALUi 32 (ALU result/address), Bi 32 (store data), condi 1 (branch condition from EX).
REQ-004 SHALL have outputs IRo 32 (instruction to WB), ALUo 32 (latched ALU result), LMDo 32 (load data), branch_taken 1, branch_target 32, stall 1 (hold upstream).
REQ-005 SHALL have a memory port: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1.

Function
REQ-006 SHALL update all state on the falling edge of clk.
REQ-007 SHALL, on a falling edge with stall=0, capture IRi, ALUi, Bi and condi into internal IR, ALU, B and COND; with stall=1 these hold.
REQ-008 SHALL decode opcode IR[31:26]: LW=100011 (load), SW=101011 (store), BEQZ=000100 (branch); all other opcodes pass through with no memory access.
REQ-009 SHALL implement FSM IDLE/ACCESS: a capture of LW/SW moves to ACCESS; any other capture stays in IDLE.
REQ-010 SHALL, in ACCESS, drive mem_req=1, mem_addr=ALU, mem_we=1 for SW/0 for LW, mem_wdata=B, and stall=1; in IDLE mem_req=0, mem_we=0, stall=0.
REQ-011 SHALL sample mem_ack only in ACCESS: on a falling edge with mem_ack=1, return to IDLE and, for LW, load LMD<=mem_rdata; mem_ack in IDLE is ignored.
REQ-012 SHALL give load/store a minimum latency of one extra cycle (ack on first ACCESS edge); no timeout, so stall holds indefinitely without ack.
REQ-013 SHALL drive IRo=32'h0 (bubble) in ACCESS and IRo=IR in IDLE, so WB commits each instruction exactly once.
REQ-014 SHALL drive ALUo=ALU and LMDo=LMD continuously; LMD holds its value across non-load instructions.
REQ-015 SHALL drive branch_taken=(opcode==BEQZ)&&COND and branch_target=ALU combinationally from latched state; branch_taken=0 in ACCESS.
REQ-016 SHALL not capture a new instruction on the same edge that ack completes; capture resumes on the following falling edge.

Reset
REQ-017 SHALL, while rst=0, force IR, ALU, B, COND, LMD to 0 and FSM to IDLE immediately, regardless of clk.
REQ-018 SHALL, on reset mid-ACCESS, drop mem_req, mem_we and stall to 0 immediately; the pending access is abandoned and a late mem_ack is ignored.
REQ-019 SHALL present after reset: IRo=0, ALUo=0, LMDo=0, branch_taken=0, branch_target=0, stall=0, mem_req=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-020 SHALL, with MEM_ALIGN_CHECK_EN defined, add output misalign 1 and, when a captured LW/SW has ALUi[1:0]!=00, stay in IDLE, issue no access, drive IRo=0 and misalign=1 until the next capture; misalign resets to 0.
REQ-021 SHALL, without MEM_ALIGN_CHECK_EN, omit the misalign port and pass addresses to mem_addr unmodified.

Structure
REQ-022 SHALL take opcode constants (LW, SW, BEQZ), FSM state encoding and the bubble value 32'h0 from the shared CPU definitions package.
REQ-023 SHALL contain one sub-module, mem_access_fsm, owning state, mem_req/mem_we/stall generation and ack sampling; the datapath registers stay in mem_seg.

Verification
REQ-024 Bench SHALL check: reset asserted mid-ACCESS with mem_req=1 -> mem_req, stall, IRo drop to 0 asynchronously; late mem_ack ignored.
REQ-025 Bench SHALL check: LW, ALUi=0x100, ack after 3 cycles with mem_rdata=0xDEADBEEF -> stall=1 for 3 cycles, IRo=0 meanwhile, then LMDo=0xDEADBEEF, IRo=LW word.
REQ-026 Bench SHALL check: SW, ALUi=0x20, Bi=0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 until ack; LMDo unchanged.
REQ-027 Bench SHALL check: BEQZ with condi=1, ALUi=0x40 -> branch_taken=1, branch_target=0x40, no mem_req; with condi=0 -> branch_taken=0.
REQ-028 Bench SHALL check: ADD (opcode 000000) back-to-back after LW with ack on first edge -> ADD captured on the edge after ack, never on the ack edge.
REQ-029 Bench SHALL check, with MEM_ALIGN_CHECK_EN: LW with ALUi=0x102 -> misalign=1, mem_req stays 0, IRo=0.
